muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit for the next-generation pipelined core, which adds the M extension. It sits in EX beside the ALU. It accepts one operation per start pulse, holds the EX stage via o_busy while it iterates, and returns a registered result with a one-cycle o_valid pulse. It is parametrised in data width and in bits retired per cycle, so area can be traded against latency.

---
 rtl/muldiv_unit.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits retired per CALC cycle, sign fix-up in a single FIX cycle.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int BPC = BITS_PER_CYCLE;
  localparam logic [CW-1:0]   LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  if (!((BPC == 1) || (BPC == 2) || (BPC == 4)) || (XLEN % BPC != 0) ||
      (XLEN < 8) || (XLEN % 2 != 0)) begin : g_badParam
    $error("muldiv_unit: illegal XLEN/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [CW-1:0]   r_cnt;
  logic            r_negRes;
  logic            r_negRem;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_result;
  logic            r_busy;
  logic            r_valid;

  logic            w_aSigned;
  logic            w_bSigned;
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN-1:0] w_aMag;
  logic [XLEN-1:0] w_bMag;
  logic            w_divZero;
  logic            w_ovf;
  logic            w_bypass;
  logic [XLEN-1:0] w_special;

  // Operand decode at the accepting edge: sign flags, magnitudes and the divide shortcuts.
  always_comb begin
    w_aSigned = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd6);
    w_bSigned = (i_op == 3'd1) || (i_op == 3'd4) || (i_op == 3'd6);
    w_aNeg    = w_aSigned && i_a[XLEN-1];
    w_bNeg    = w_bSigned && i_b[XLEN-1];
    w_aMag    = w_aNeg ? -i_a : i_a;
    w_bMag    = w_bNeg ? -i_b : i_b;
    w_divZero = (i_b == '0);
    w_ovf     = (i_a == SMIN) && (i_b == '1) && !i_op[0];
    w_bypass  = i_op[2] && (w_divZero || w_ovf);
    if (w_divZero) w_special = i_op[1] ? i_a : '1;
    else           w_special = i_op[1] ? '0 : i_a;
  end

  logic [XLEN+BPC-1:0] w_addend;
  logic [XLEN+BPC-1:0] w_sum;
  logic [XLEN:0]       w_divRem;
  logic [XLEN:0]       w_divShift;
  logic [XLEN-1:0]     w_divQuo;

  // One CALC step: BPC multiplier bits of shift-add, or BPC unrolled restoring-divide steps.
  always_comb begin
    w_addend = '0;
    for (int j = 0; j < BPC; j++) begin
      if (r_lo[j]) w_addend = w_addend + ({{BPC{1'b0}}, r_b} << j);
    end
    w_sum = {{BPC{1'b0}}, r_hi} + w_addend;

    w_divRem   = {1'b0, r_hi};
    w_divQuo   = r_lo;
    w_divShift = '0;
    for (int k = 0; k < BPC; k++) begin
      w_divShift = {w_divRem[XLEN-1:0], w_divQuo[XLEN-1]};
      w_divQuo   = {w_divQuo[XLEN-2:0], 1'b0};
      if (w_divShift >= {1'b0, r_b}) begin
        w_divRem    = w_divShift - {1'b0, r_b};
        w_divQuo[0] = 1'b1;
      end else begin
        w_divRem    = w_divShift;
      end
    end
  end

  logic [2*XLEN-1:0] w_prodFix;
  logic [XLEN-1:0]   w_quoFix;
  logic [XLEN-1:0]   w_remFix;
  logic [XLEN-1:0]   w_fixResult;

  always_comb begin
    w_prodFix = r_negRes ? -{r_hi, r_lo} : {r_hi, r_lo};
    w_quoFix  = r_negRes ? -r_lo : r_lo;
    w_remFix  = r_negRem ? -r_hi : r_hi;
    case (r_op)
      3'd0:                 w_fixResult = w_prodFix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:     w_fixResult = w_prodFix[2*XLEN-1:XLEN];
      3'd4, 3'd5:           w_fixResult = w_quoFix;
      default:              w_fixResult = w_remFix;
    endcase
  end

  // Control FSM; reset beats flush, flush beats everything else and leaves the result untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_cnt    <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          if (i_start) begin
            r_op     <= i_op;
            r_negRes <= w_aNeg ^ w_bNeg;
            r_negRem <= w_aNeg;
            r_hi     <= '0;
            r_lo     <= w_aMag;
            r_b      <= w_bMag;
            r_cnt    <= '0;
            if (w_bypass) begin
              r_result <= w_special;
              r_valid  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (r_op[2]) begin
            r_hi <= w_divRem[XLEN-1:0];
            r_lo <= w_divQuo;
          end else begin
            r_hi <= w_sum[XLEN+BPC-1:BPC];
            r_lo <= {w_sum[BPC-1:0], r_lo[XLEN-1:BPC]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_fixResult;
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule
